// File: rtl/eth_pkg.sv
// Shared types and helpers for the Ethernet AXI-Stream frame shapers.
package eth_pkg;

    localparam int FCS_LENGTH     = 4;
    localparam int MAX_KEEP_WIDTH = 8;

    typedef enum logic [1:0] {
        PASS,
        PAD,
        DROP
    } state_t;

    // Which stat pulse an output frame earns once its last beat leaves.
    typedef enum logic [1:0] {
        KIND_GOOD,
        KIND_PADDED,
        KIND_TRUNC
    } frame_kind_t;

    // Low-aligned mask with min(n, MAX_KEEP_WIDTH) bits set; callers cast to their lane count.
    function automatic logic [MAX_KEEP_WIDTH-1:0] keep_from_count(input int unsigned n);
        logic [MAX_KEEP_WIDTH-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_KEEP_WIDTH; i++) begin
            if (i < n) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/eth_axis_keep_count.sv
// Combinational popcount of an AXI-Stream tkeep vector.
module eth_axis_keep_count #(
    parameter int KEEP_WIDTH = 1
) (
    input  logic [KEEP_WIDTH-1:0]            keep,
    output logic [$clog2(KEEP_WIDTH+1)-1:0]  count
);

    localparam int COUNT_WIDTH = $clog2(KEEP_WIDTH + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            count = count + COUNT_WIDTH'(keep[i]);
        end
    end

endmodule

// File: rtl/eth_axis_tx_frame_shaper.sv
// TX frame shaper: pads short frames, truncates long ones, drops the overflow,
// and pulses one status flag per output frame through a registered output slice.
module eth_axis_tx_frame_shaper
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int KEEP_WIDTH       = DATA_WIDTH / 8,
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int MAX_FRAME_LENGTH = 1518,
    parameter int ENABLE_PADDING   = 1
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,

    output logic                  stat_frame_good,
    output logic                  stat_frame_padded,
    output logic                  stat_frame_truncated
);

    localparam int          CNT_WIDTH   = $clog2(MAX_FRAME_LENGTH + 1);
    localparam int          BYTES_WIDTH = $clog2(KEEP_WIDTH + 1);
    localparam logic [31:0] MIN_PAYLOAD = 32'(MIN_FRAME_LENGTH - FCS_LENGTH);
    localparam logic [31:0] MAX_PAYLOAD = 32'(MAX_FRAME_LENGTH - FCS_LENGTH);
    localparam logic [31:0] KEEP_BYTES  = 32'(KEEP_WIDTH);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pad_user_q, pad_user_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic [KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic                  m_tuser_q, m_tuser_d;
    frame_kind_t           kind_q, kind_d;
    logic                  stat_good_q, stat_good_d;
    logic                  stat_padded_q, stat_padded_d;
    logic                  stat_trunc_q, stat_trunc_d;

    logic [BYTES_WIDTH-1:0] beat_bytes;
    logic [31:0]            cnt_ext, total, trunc_room, pad_room;
    logic [KEEP_WIDTH-1:0]  trunc_keep, pad_keep;
    logic [DATA_WIDTH-1:0]  fill_data;
    logic                   out_free;

    eth_axis_keep_count #(
        .KEEP_WIDTH(KEEP_WIDTH)
    ) u_keep_count (
        .keep  (s_axis_tkeep),
        .count (beat_bytes)
    );

    assign cnt_ext    = 32'(cnt_q);
    assign total      = cnt_ext + 32'(beat_bytes);
    assign trunc_room = MAX_PAYLOAD - cnt_ext;
    // Wraps when the frame is already past the pad target; only consulted below it.
    assign pad_room   = MIN_PAYLOAD - cnt_ext;
    assign trunc_keep = KEEP_WIDTH'(keep_from_count(trunc_room));
    assign pad_keep   = KEEP_WIDTH'(keep_from_count(pad_room));
    assign out_free   = !m_tvalid_q || m_axis_tready;

    for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_fill
        assign fill_data[gi*8 +: 8] = s_axis_tkeep[gi] ? s_axis_tdata[gi*8 +: 8] : 8'h00;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pad_user_d    = pad_user_q;
        m_tdata_d     = m_tdata_q;
        m_tkeep_d     = m_tkeep_q;
        m_tvalid_d    = m_tvalid_q && !m_axis_tready;
        m_tlast_d     = m_tlast_q;
        m_tuser_d     = m_tuser_q;
        kind_d        = kind_q;
        s_axis_tready = 1'b0;

        // Pulses follow the transfer of a frame's final beat by one cycle.
        stat_good_d   = m_tvalid_q && m_axis_tready && m_tlast_q && (kind_q == KIND_GOOD);
        stat_padded_d = m_tvalid_q && m_axis_tready && m_tlast_q && (kind_q == KIND_PADDED);
        stat_trunc_d  = m_tvalid_q && m_axis_tready && m_tlast_q && (kind_q == KIND_TRUNC);

        case (state_q)
            PASS: begin
                s_axis_tready = out_free;
                if (s_axis_tvalid && out_free) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = s_axis_tdata;
                    m_tkeep_d  = s_axis_tkeep;
                    m_tlast_d  = s_axis_tlast;
                    m_tuser_d  = s_axis_tlast && s_axis_tuser;
                    kind_d     = KIND_GOOD;
                    cnt_d      = s_axis_tlast ? '0 : CNT_WIDTH'(total);
                    if (total > MAX_PAYLOAD) begin
                        m_tkeep_d = trunc_keep;
                        m_tlast_d = 1'b1;
                        m_tuser_d = 1'b1;
                        kind_d    = KIND_TRUNC;
                        cnt_d     = '0;
                        if (!s_axis_tlast) begin
                            state_d = DROP;
                        end
                    end else if ((ENABLE_PADDING != 0) && s_axis_tlast && (total < MIN_PAYLOAD)) begin
                        m_tdata_d  = fill_data;
                        pad_user_d = s_axis_tuser;
                        kind_d     = KIND_PADDED;
                        if (cnt_ext + KEEP_BYTES >= MIN_PAYLOAD) begin
                            m_tkeep_d = pad_keep;
                            m_tlast_d = 1'b1;
                            m_tuser_d = s_axis_tuser;
                            cnt_d     = '0;
                        end else begin
                            m_tkeep_d = '1;
                            m_tlast_d = 1'b0;
                            m_tuser_d = 1'b0;
                            cnt_d     = CNT_WIDTH'(cnt_ext + KEEP_BYTES);
                            state_d   = PAD;
                        end
                    end
                end
            end
            PAD: begin
                if (out_free) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = '0;
                    kind_d     = KIND_PADDED;
                    if (cnt_ext + KEEP_BYTES >= MIN_PAYLOAD) begin
                        m_tkeep_d = pad_keep;
                        m_tlast_d = 1'b1;
                        m_tuser_d = pad_user_q;
                        cnt_d     = '0;
                        state_d   = PASS;
                    end else begin
                        m_tkeep_d = '1;
                        m_tlast_d = 1'b0;
                        m_tuser_d = 1'b0;
                        cnt_d     = CNT_WIDTH'(cnt_ext + KEEP_BYTES);
                    end
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    cnt_d   = '0;
                    state_d = PASS;
                end
            end
            default: begin
                state_d = PASS;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= PASS;
            cnt_q         <= '0;
            pad_user_q    <= 1'b0;
            m_tdata_q     <= '0;
            m_tkeep_q     <= '0;
            m_tvalid_q    <= 1'b0;
            m_tlast_q     <= 1'b0;
            m_tuser_q     <= 1'b0;
            kind_q        <= KIND_GOOD;
            stat_good_q   <= 1'b0;
            stat_padded_q <= 1'b0;
            stat_trunc_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pad_user_q    <= pad_user_d;
            m_tdata_q     <= m_tdata_d;
            m_tkeep_q     <= m_tkeep_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tlast_q     <= m_tlast_d;
            m_tuser_q     <= m_tuser_d;
            kind_q        <= kind_d;
            stat_good_q   <= stat_good_d;
            stat_padded_q <= stat_padded_d;
            stat_trunc_q  <= stat_trunc_d;
        end
    end

    assign m_axis_tdata         = m_tdata_q;
    assign m_axis_tkeep         = m_tkeep_q;
    assign m_axis_tvalid        = m_tvalid_q;
    assign m_axis_tlast         = m_tlast_q;
    assign m_axis_tuser         = m_tuser_q;
    assign stat_frame_good      = stat_good_q;
    assign stat_frame_padded    = stat_padded_q;
    assign stat_frame_truncated = stat_trunc_q;

endmodule

// File: tb/tb_eth_axis_tx_frame_shaper.sv
// Bench for the TX frame shaper at 32-bit width: a frame-level model predicts every
// output beat and stat pulse; directed frames also pin lengths/keeps/flags to literals.
module tb_eth_axis_tx_frame_shaper;

    localparam int DW   = 32;
    localparam int KW   = 4;
    localparam int MINP = 60;
    localparam int MAXP = 1514;

    typedef bit [7:0] bq_t[$];

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
        logic [2:0]    stat;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic          s_tuser;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          m_tuser;
    logic          st_good;
    logic          st_padded;
    logic          st_trunc;

    always #5 clk = ~clk;

    eth_axis_tx_frame_shaper #(
        .DATA_WIDTH       (DW),
        .KEEP_WIDTH       (KW),
        .MIN_FRAME_LENGTH (64),
        .MAX_FRAME_LENGTH (1518),
        .ENABLE_PADDING   (1)
    ) dut (
        .clock                (clk),
        .reset                (reset),
        .s_axis_tdata         (s_tdata),
        .s_axis_tkeep         (s_tkeep),
        .s_axis_tvalid        (s_tvalid),
        .s_axis_tready        (s_tready),
        .s_axis_tlast         (s_tlast),
        .s_axis_tuser         (s_tuser),
        .m_axis_tdata         (m_tdata),
        .m_axis_tkeep         (m_tkeep),
        .m_axis_tvalid        (m_tvalid),
        .m_axis_tready        (m_tready),
        .m_axis_tlast         (m_tlast),
        .m_axis_tuser         (m_tuser),
        .stat_frame_good      (st_good),
        .stat_frame_padded    (st_padded),
        .stat_frame_truncated (st_trunc)
    );

    beat_t      exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         frames_out = 0;
    bit         mon_en = 1'b0;
    bit         bp_en  = 1'b0;
    int         obs_len, obs_beats;
    logic [3:0] obs_keep;
    logic       obs_user;
    logic [2:0] obs_stat;
    logic [7:0] obs_first;

    always @(posedge clk) begin
        #1;
        m_tready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int popc(input logic [KW-1:0] k);
        int c = 0;
        for (int i = 0; i < KW; i++) c += int'(k[i]);
        return c;
    endfunction

    function automatic bq_t make_frame(input int len, input int seed);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'(seed + i));
        return q;
    endfunction

    // Frame-level model: output length = min(max(len, 60), 1514), zero fill, tuser rules.
    task automatic push_expect(input bq_t b, input bit user);
        int         len;
        int         out_len;
        bit         u;
        logic [2:0] st;
        beat_t      e;
        len = b.size();
        if (len > MAXP) begin
            out_len = MAXP; u = 1'b1; st = 3'b001;
        end else if (len < MINP) begin
            out_len = MINP; u = user; st = 3'b010;
        end else begin
            out_len = len; u = user; st = 3'b100;
        end
        for (int p = 0; p < out_len; p += KW) begin
            e = '0;
            for (int l = 0; l < KW; l++) begin
                if (p + l < out_len) begin
                    e.keep[l] = 1'b1;
                    e.data[l*8 +: 8] = (p + l < len) ? b[p + l] : 8'h00;
                end
            end
            e.last = (p + KW >= out_len);
            e.user = e.last ? u : 1'b0;
            e.stat = e.last ? st : 3'b000;
            exp_q.push_back(e);
        end
    endtask

    // Drives a frame; with abort_beat >= 0 it returns leaving that beat presented.
    task automatic send_frame(input bq_t b, input bit user, input int abort_beat, output int cycles);
        int            nb;
        int            waits;
        bit            got;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        nb = (b.size() + KW - 1) / KW;
        cycles = 0;
        for (int i = 0; i < nb; i++) begin
            d = {KW{8'hEE}};
            k = '0;
            for (int l = 0; l < KW; l++) begin
                if (i * KW + l < b.size()) begin
                    d[l*8 +: 8] = b[i * KW + l];
                    k[l] = 1'b1;
                end
            end
            s_tdata  = d;
            s_tkeep  = k;
            s_tlast  = (i == nb - 1);
            s_tuser  = (i == nb - 1) ? user : 1'b0;
            s_tvalid = 1'b1;
            if (i == abort_beat) return;
            waits = 0;
            got = 1'b0;
            while (!got && waits < 5000) begin
                @(negedge clk);
                got = s_tready;
                tick();
                cycles++;
                waits++;
            end
            if (!got) begin
                chk(1'b0, "input_handshake_timeout", 64'(waits), 64'(0));
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int t = 0;
        while (frames_out < target && t < 20000) begin
            tick();
            t++;
        end
        chk(frames_out >= target, "frame_timeout", 64'(frames_out), 64'(target));
        repeat (2) tick();
    endtask

    task automatic run_frame(input int len, input bit user, input int seed, output int cycles);
        bq_t b;
        int  target;
        b = make_frame(len, seed);
        push_expect(b, user);
        obs_stat = 3'b000;
        target = frames_out + 1;
        send_frame(b, user, -1, cycles);
        wait_frames(target);
    endtask

    task automatic monitor_loop();
        beat_t       e;
        bit          stall;
        logic [2:0]  exp_stat, st_next, st_now;
        logic [37:0] prev, cur, act, ex;
        logic [DW-1:0] mask;
        int          cur_bytes, cur_beats;
        stall = 1'b0; exp_stat = '0; prev = '0; cur_bytes = 0; cur_beats = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stall = 1'b0; exp_stat = '0; cur_bytes = 0; cur_beats = 0;
                continue;
            end
            st_now = {st_good, st_padded, st_trunc};
            chk(st_now == exp_stat, "stat_pulse", 64'(st_now), 64'(exp_stat));
            if (st_now != 3'b000) obs_stat = st_now;
            st_next = 3'b000;
            cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
            if (stall) chk(m_tvalid && cur == prev, "hold_stable", 64'(cur), 64'(prev));
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", 64'(cur), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    for (int l = 0; l < KW; l++) mask[l*8 +: 8] = {8{e.keep[l]}};
                    act = {m_tdata & mask, m_tkeep, m_tlast, m_tuser};
                    ex  = {e.data, e.keep, e.last, e.user};
                    chk(act == ex, "out_beat", 64'(act), 64'(ex));
                    if (e.last) st_next = e.stat;
                end
                if (cur_beats == 0) obs_first = m_tdata[7:0];
                cur_beats++;
                cur_bytes += popc(m_tkeep);
                if (m_tlast) begin
                    obs_len = cur_bytes; obs_beats = cur_beats;
                    obs_keep = m_tkeep; obs_user = m_tuser;
                    frames_out++;
                    cur_bytes = 0; cur_beats = 0;
                end
            end
            exp_stat = st_next;
            stall = m_tvalid && !m_tready;
            prev = cur;
        end
    endtask

    initial begin
        int  cyc;
        int  start;
        int  t;
        int  len;
        bit  user;
        bq_t b;

        reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0;
        fork
            monitor_loop();
        join_none
        repeat (3) tick();
        chk({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, st_good, st_padded, st_trunc} == '0,
            "reset_outputs", 64'({m_tvalid, m_tkeep, m_tlast, m_tuser}), 64'(0));
        reset = 1'b0;
        tick();
        chk(s_tready == 1'b1, "tready_after_reset", 64'(s_tready), 64'(1));
        mon_en = 1'b1;

        run_frame(20, 1'b0, 8'h10, cyc);
        $display("frame len=20 user=0: out_len=%0d beats=%0d keep=%h user=%0d stat=%b", obs_len, obs_beats, obs_keep, obs_user, obs_stat);
        chk(obs_len == 60, "pad20_len", 64'(obs_len), 64'(60));
        chk(obs_beats == 15, "pad20_beats", 64'(obs_beats), 64'(15));
        chk(obs_keep == 4'hF, "pad20_keep", 64'(obs_keep), 64'hF);
        chk(obs_user == 1'b0, "pad20_user", 64'(obs_user), 64'(0));
        chk(obs_stat == 3'b010, "pad20_stat", 64'(obs_stat), 64'(3'b010));

        run_frame(13, 1'b1, 8'h40, cyc);
        $display("frame len=13 user=1: out_len=%0d beats=%0d keep=%h user=%0d stat=%b", obs_len, obs_beats, obs_keep, obs_user, obs_stat);
        chk(obs_len == 60, "pad13_len", 64'(obs_len), 64'(60));
        chk(obs_user == 1'b1, "pad13_user", 64'(obs_user), 64'(1));
        chk(obs_stat == 3'b010, "pad13_stat", 64'(obs_stat), 64'(3'b010));

        run_frame(58, 1'b0, 8'h70, cyc);
        $display("frame len=58 user=0: out_len=%0d beats=%0d keep=%h user=%0d stat=%b", obs_len, obs_beats, obs_keep, obs_user, obs_stat);
        chk(obs_len == 60, "pad58_len", 64'(obs_len), 64'(60));
        chk(obs_beats == 15, "pad58_beats", 64'(obs_beats), 64'(15));

        start = frames_out;
        run_frame(1600, 1'b0, 8'h01, cyc);
        $display("frame len=1600 user=0: out_len=%0d beats=%0d keep=%h user=%0d stat=%b", obs_len, obs_beats, obs_keep, obs_user, obs_stat);
        chk(obs_len == 1514, "trunc_len", 64'(obs_len), 64'(1514));
        chk(obs_beats == 379, "trunc_beats", 64'(obs_beats), 64'(379));
        chk(obs_keep == 4'h3, "trunc_keep", 64'(obs_keep), 64'h3);
        chk(obs_user == 1'b1, "trunc_user", 64'(obs_user), 64'(1));
        chk(obs_stat == 3'b001, "trunc_stat", 64'(obs_stat), 64'(3'b001));
        chk(frames_out == start + 1, "trunc_one_frame", 64'(frames_out - start), 64'(1));

        run_frame(60, 1'b1, 8'h22, cyc);
        $display("frame len=60 user=1: out_len=%0d cycles=%0d stat=%b", obs_len, cyc, obs_stat);
        chk(obs_len == 60, "exact_min_len", 64'(obs_len), 64'(60));
        chk(obs_user == 1'b1, "exact_min_user", 64'(obs_user), 64'(1));
        chk(obs_stat == 3'b100, "exact_min_stat", 64'(obs_stat), 64'(3'b100));
        chk(cyc == 15, "full_throughput", 64'(cyc), 64'(15));

        run_frame(61, 1'b0, 8'h33, cyc);
        $display("frame len=61 user=0: out_len=%0d keep=%h stat=%b", obs_len, obs_keep, obs_stat);
        chk(obs_keep == 4'h1, "len61_keep", 64'(obs_keep), 64'h1);
        chk(obs_stat == 3'b100, "len61_stat", 64'(obs_stat), 64'(3'b100));

        run_frame(1514, 1'b0, 8'h55, cyc);
        $display("frame len=1514 user=0: out_len=%0d keep=%h user=%0d stat=%b", obs_len, obs_keep, obs_user, obs_stat);
        chk(obs_len == 1514, "exact_max_len", 64'(obs_len), 64'(1514));
        chk(obs_user == 1'b0, "exact_max_user", 64'(obs_user), 64'(0));
        chk(obs_stat == 3'b100, "exact_max_stat", 64'(obs_stat), 64'(3'b100));

        run_frame(1515, 1'b0, 8'h66, cyc);
        $display("frame len=1515 user=0: out_len=%0d keep=%h user=%0d stat=%b", obs_len, obs_keep, obs_user, obs_stat);
        chk(obs_len == 1514, "max_plus1_len", 64'(obs_len), 64'(1514));
        chk(obs_user == 1'b1, "max_plus1_user", 64'(obs_user), 64'(1));
        chk(obs_stat == 3'b001, "max_plus1_stat", 64'(obs_stat), 64'(3'b001));

        // Random frames streamed back to back under 30% output backpressure.
        start = frames_out;
        bp_en = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len  = ($urandom_range(0, 99) < 2) ? int'($urandom_range(1400, 1700)) : int'($urandom_range(1, 150));
            user = 1'($urandom_range(0, 1));
            b.delete();
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            push_expect(b, user);
            send_frame(b, user, -1, cyc);
        end
        t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            tick();
            t++;
        end
        bp_en = 1'b0;
        repeat (3) tick();
        $display("random phase: frames_out=%0d pending=%0d", frames_out - start, exp_q.size());
        chk(exp_q.size() == 0, "random_drain", 64'(exp_q.size()), 64'(0));
        chk(frames_out == start + 1000, "random_frame_count", 64'(frames_out - start), 64'(1000));

        // Reset in the 3rd beat of a 100-byte frame.
        mon_en = 1'b0;
        b = make_frame(100, 8'h30);
        send_frame(b, 1'b0, 2, cyc);
        reset = 1'b1;
        tick();
        $display("mid-frame reset: m_tvalid=%0d m_tkeep=%h", m_tvalid, m_tkeep);
        chk({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, st_good, st_padded, st_trunc} == '0,
            "mid_reset_outputs", 64'({m_tvalid, m_tdata}), 64'(0));
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        reset    = 1'b0;
        tick();
        chk(s_tready == 1'b1, "tready_after_mid_reset", 64'(s_tready), 64'(1));
        exp_q.delete();
        mon_en = 1'b1;

        run_frame(100, 1'b0, 8'hA5, cyc);
        $display("frame after reset len=100: out_len=%0d first=%h stat=%b", obs_len, obs_first, obs_stat);
        chk(obs_first == 8'hA5, "first_byte_after_reset", 64'(obs_first), 64'hA5);
        chk(obs_len == 100, "len_after_reset", 64'(obs_len), 64'(100));
        chk(obs_stat == 3'b100, "stat_after_reset", 64'(obs_stat), 64'(3'b100));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
